// File: rtl/my_register_file.sv
// my_register_file
//
// Multi-entry register file for the 4-bit CPU datapath. It holds NUM_REGS
// words of REGISTER_WIDTH bits. It has one write port, which applies an
// in-place operation (LOAD / INC / DEC / CLEAR) to one register per cycle,
// and two independent combinational read ports. Registered carry and zero
// flags describe the most recent accepted write.
//
// Ports:
//   clk_i       : clock, rising edge active
//   reset_i     : asynchronous, active-high reset
//   write_en_i  : apply op_i to register waddr_i at the next rising edge
//   waddr_i     : write/operate address (addresses >= NUM_REGS are ignored)
//   op_i        : 00 LOAD in_i, 01 INC, 10 DEC, 11 CLEAR
//   in_i        : load data
//   raddr_a_i   : read address, port A
//   raddr_b_i   : read address, port B
//   out_a_o     : read data, port A (0 for addresses >= NUM_REGS)
//   out_b_o     : read data, port B (0 for addresses >= NUM_REGS)
//   carry_o     : wrap/borrow flag from the last accepted write
//   zero_o      : 1 when the last accepted write produced 0
//
// Handshake: there is none. Every cycle with write_en_i=1 and an in-range
// waddr_i is a write that is accepted. Reads are pure combinational lookups.

module my_register_file #(
  parameter int                        REGISTER_WIDTH = 4,
  parameter int                        NUM_REGS       = 4,
  parameter int                        ADDR_WIDTH     = 2,
  parameter logic [REGISTER_WIDTH-1:0] RESET_VALUE    = '0,
  parameter bit                        BYPASS         = 1'b1
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      write_en_i,
  input  logic [ADDR_WIDTH-1:0]     waddr_i,
  input  logic [1:0]                op_i,
  input  logic [REGISTER_WIDTH-1:0] in_i,
  input  logic [ADDR_WIDTH-1:0]     raddr_a_i,
  input  logic [ADDR_WIDTH-1:0]     raddr_b_i,
  output logic [REGISTER_WIDTH-1:0] out_a_o,
  output logic [REGISTER_WIDTH-1:0] out_b_o,
  output logic                      carry_o,
  output logic                      zero_o
);

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_INC   = 2'b01;
  localparam logic [1:0] OP_DEC   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  // One extra bit so that NUM_REGS itself is representable when it equals
  // 2**ADDR_WIDTH.
  localparam logic [ADDR_WIDTH:0] NUM_REGS_W = (ADDR_WIDTH+1)'(NUM_REGS);

  logic [REGISTER_WIDTH-1:0] regs [NUM_REGS];
  logic [REGISTER_WIDTH-1:0] cur;
  logic [REGISTER_WIDTH-1:0] nv;
  logic                      nv_carry;
  logic                      wr_ok;
  logic                      carry_q;
  logic                      zero_q;

  // Gate with reset so that the bypass path cannot show a next value while
  // the array is held at RESET_VALUE.
  assign wr_ok = write_en_i && !reset_i && ({1'b0, waddr_i} < NUM_REGS_W);

  // Current contents of the addressed register. The lookup is written as a
  // loop so that a non-power-of-two NUM_REGS never indexes past the array.
  always_comb begin
    cur = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (waddr_i == ADDR_WIDTH'(i)) cur = regs[i];
    end
  end

  // Next value and carry for the write-port operation.
  always_comb begin
    nv       = cur;
    nv_carry = 1'b0;
    case (op_i)
      OP_LOAD: begin
        nv       = in_i;
        nv_carry = 1'b0;
      end
      OP_INC: begin
        nv       = cur + REGISTER_WIDTH'(1);
        nv_carry = &cur;
      end
      OP_DEC: begin
        nv       = cur - REGISTER_WIDTH'(1);
        nv_carry = (cur == '0);
      end
      OP_CLEAR: begin
        nv       = '0;
        nv_carry = 1'b0;
      end
      default: begin
        nv       = cur;
        nv_carry = 1'b0;
      end
    endcase
  end

  // Storage and flags.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VALUE;
      carry_q <= 1'b0;
      zero_q  <= (RESET_VALUE == '0);
    end else if (wr_ok) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (waddr_i == ADDR_WIDTH'(i)) regs[i] <= nv;
      end
      carry_q <= nv_carry;
      zero_q  <= (nv == '0);
    end
  end

  // Read ports. Out-of-range addresses fall through to 0. The bypass can only
  // match in-range addresses because wr_ok already requires one.
  always_comb begin
    out_a_o = '0;
    out_b_o = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (raddr_a_i == ADDR_WIDTH'(i)) out_a_o = regs[i];
      if (raddr_b_i == ADDR_WIDTH'(i)) out_b_o = regs[i];
    end
    if (BYPASS && wr_ok) begin
      if (raddr_a_i == waddr_i) out_a_o = nv;
      if (raddr_b_i == waddr_i) out_b_o = nv;
    end
  end

  assign carry_o = carry_q;
  assign zero_o  = zero_q;

endmodule

// File: tb/tb_my_register_file.sv
// Directed bench for my_register_file. Four instances share one stimulus bus:
//   [0] defaults, [1] RESET_VALUE=4'b0101, [2] BYPASS=0, [3] NUM_REGS=3.
module tb_my_register_file;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_INC   = 2'b01;
  localparam logic [1:0] OP_DEC   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  logic       clk;
  logic       rst;
  logic       we;
  logic [1:0] waddr;
  logic [1:0] op;
  logic [3:0] din;
  logic [1:0] raddr_a;
  logic [1:0] raddr_b;
  logic [3:0] out_a [4];
  logic [3:0] out_b [4];
  logic       carry [4];
  logic       zero  [4];

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUTs ----------------
  my_register_file u_dut0 (
    .clk_i(clk), .reset_i(rst), .write_en_i(we), .waddr_i(waddr), .op_i(op),
    .in_i(din), .raddr_a_i(raddr_a), .raddr_b_i(raddr_b),
    .out_a_o(out_a[0]), .out_b_o(out_b[0]), .carry_o(carry[0]), .zero_o(zero[0])
  );

  my_register_file #(.RESET_VALUE(4'b0101)) u_dut_rv (
    .clk_i(clk), .reset_i(rst), .write_en_i(we), .waddr_i(waddr), .op_i(op),
    .in_i(din), .raddr_a_i(raddr_a), .raddr_b_i(raddr_b),
    .out_a_o(out_a[1]), .out_b_o(out_b[1]), .carry_o(carry[1]), .zero_o(zero[1])
  );

  my_register_file #(.BYPASS(1'b0)) u_dut_nb (
    .clk_i(clk), .reset_i(rst), .write_en_i(we), .waddr_i(waddr), .op_i(op),
    .in_i(din), .raddr_a_i(raddr_a), .raddr_b_i(raddr_b),
    .out_a_o(out_a[2]), .out_b_o(out_b[2]), .carry_o(carry[2]), .zero_o(zero[2])
  );

  my_register_file #(.NUM_REGS(3)) u_dut_n3 (
    .clk_i(clk), .reset_i(rst), .write_en_i(we), .waddr_i(waddr), .op_i(op),
    .in_i(din), .raddr_a_i(raddr_a), .raddr_b_i(raddr_b),
    .out_a_o(out_a[3]), .out_b_o(out_b[3]), .carry_o(carry[3]), .zero_o(zero[3])
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic read_check(input string tag, input int k, input logic [1:0] addr,
                            input logic [3:0] exp);
    raddr_a = addr;
    raddr_b = addr;
    #1;
    check({tag, "_a"}, 8'(out_a[k]), 8'(exp));
    check({tag, "_b"}, 8'(out_b[k]), 8'(exp));
  endtask

  task automatic flag_check(input string tag, input int k, input logic c, input logic z);
    check({tag, "_carry"}, 8'(carry[k]), 8'(c));
    check({tag, "_zero"},  8'(zero[k]),  8'(z));
  endtask

  // ---------------- driver ----------------
  // Presents one write, lets one rising edge take it, and returns at edge+1.
  task automatic write_op(input logic [1:0] addr, input logic [1:0] o, input logic [3:0] d);
    waddr = addr;
    op    = o;
    din   = d;
    we    = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset held for 45 ns while a LOAD of 1111 is presented on every edge.
    rst = 1'b1; we = 1'b1; op = OP_LOAD; din = 4'hF; waddr = 2'd1;
    raddr_a = 2'd0; raddr_b = 2'd0;
    repeat (3) begin
      @(posedge clk);
      #2;
      for (int r = 0; r < 4; r++) begin
        raddr_a = 2'(r);
        raddr_b = 2'(3 - r);
        #1;
        check("rst_r_a",    8'(out_a[0]), 8'h0);
        check("rst_r_b",    8'(out_b[0]), 8'h0);
        check("rst_rv_r_a", 8'(out_a[1]), 8'h5);
        check("rst_rv_r_b", 8'(out_b[1]), 8'h5);
      end
      flag_check("rst", 0, 1'b0, 1'b1);
      flag_check("rst_rv", 1, 1'b0, 1'b0);
    end
    #10;            // t = 41
    we = 1'b0;
    #4 rst = 1'b0;  // t = 45
    @(negedge clk);

    // Load and hold.
    write_op(2'd1, OP_LOAD, 4'b1010);
    read_check("load_r1", 0, 2'd1, 4'b1010);
    flag_check("load", 0, 1'b0, 1'b0);
    din = 4'hF; op = OP_LOAD;
    repeat (3) @(posedge clk);
    #1;
    read_check("hold_r1", 0, 2'd1, 4'b1010);
    read_check("hold_r0", 0, 2'd0, 4'b0000);
    read_check("hold_r2", 0, 2'd2, 4'b0000);
    read_check("hold_r3", 0, 2'd3, 4'b0000);
    flag_check("hold", 0, 1'b0, 1'b0);

    // Increment wrap.
    write_op(2'd2, OP_LOAD, 4'b1110);
    write_op(2'd2, OP_INC, 4'h0);
    read_check("inc1", 0, 2'd2, 4'b1111);
    flag_check("inc1", 0, 1'b0, 1'b0);
    write_op(2'd2, OP_INC, 4'h0);
    read_check("inc2", 0, 2'd2, 4'b0000);
    flag_check("inc2", 0, 1'b1, 1'b1);
    write_op(2'd2, OP_INC, 4'h0);
    read_check("inc3", 0, 2'd2, 4'b0001);
    flag_check("inc3", 0, 1'b0, 1'b0);

    // Decrement borrow and clear.
    write_op(2'd3, OP_DEC, 4'h0);
    read_check("dec", 0, 2'd3, 4'b1111);
    flag_check("dec", 0, 1'b1, 1'b0);
    write_op(2'd3, OP_CLEAR, 4'h0);
    read_check("clr", 0, 2'd3, 4'b0000);
    flag_check("clr", 0, 1'b0, 1'b1);

    // Dual read and bypass.
    read_check("dual_r1", 0, 2'd1, 4'b1010);
    waddr = 2'd1; op = OP_LOAD; din = 4'b0110; we = 1'b1;
    raddr_a = 2'd1; raddr_b = 2'd1;
    #1;
    check("byp_a",      8'(out_a[0]), 8'h6);
    check("byp_b",      8'(out_b[0]), 8'h6);
    check("nobyp_pre",  8'(out_a[2]), 8'hA);
    @(posedge clk);
    #1;
    we = 1'b0;
    #1;
    check("nobyp_post", 8'(out_a[2]), 8'h6);
    check("byp_post",   8'(out_a[0]), 8'h6);

    // Out-of-range on the three-entry instance.
    write_op(2'd0, OP_CLEAR, 4'h0);
    flag_check("oor_pre", 3, 1'b0, 1'b1);
    waddr = 2'd3; op = OP_DEC; din = 4'h0; we = 1'b1;
    raddr_a = 2'd3; raddr_b = 2'd3;
    #1;
    check("oor_nobyp",  8'(out_a[3]), 8'h0);
    check("inrange_byp", 8'(out_a[0]), 8'hF);
    @(posedge clk);
    #1;
    we = 1'b0;
    flag_check("oor", 3, 1'b0, 1'b1);
    flag_check("inrange_dec", 0, 1'b1, 1'b0);
    read_check("oor_r3", 3, 2'd3, 4'h0);
    read_check("oor_r0", 3, 2'd0, 4'h0);
    read_check("oor_r1", 3, 2'd1, 4'h6);
    read_check("oor_r2", 3, 2'd2, 4'h1);

    // Reset between two INCs.
    write_op(2'd2, OP_INC, 4'h0);
    read_check("pre_rst_inc", 0, 2'd2, 4'h2);
    waddr = 2'd2; op = OP_INC; we = 1'b1;
    #1;
    rst = 1'b1;
    read_check("mid_rst", 0, 2'd2, 4'h0);
    check("mid_rst_rv", 8'(out_a[1]), 8'h5);
    flag_check("mid_rst", 0, 1'b0, 1'b1);
    flag_check("mid_rst_rv", 1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("rst_blocks_inc", 8'(out_a[0]), 8'h0);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    we = 1'b0;
    read_check("post_rst_inc", 0, 2'd2, 4'h1);
    flag_check("post_rst_inc", 0, 1'b0, 1'b0);
    check("post_rst_inc_rv", 8'(out_a[1]), 8'h6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
